// File: rtl/reflex_timer_if.sv
// Signal bundle between the reflex timer and its surroundings: the start and
// button levels, the millisecond tick with its phase-clear, and the result.
interface reflex_timer_if;
  logic        start;
  logic        button;
  logic        one_ms;
  logic        tick_clear;
  logic        led;
  logic [15:0] ms_bcd;
  logic        valid;
  logic        timeout;
  logic        false_start;

  // Environment side: drives the user inputs and the ms tick.
  modport master (
    output start, button, one_ms,
    input  tick_clear, led, ms_bcd, valid, timeout, false_start
  );

  // Timer side.
  modport slave (
    input  start, button, one_ms,
    output tick_clear, led, ms_bcd, valid, timeout, false_start
  );
endinterface

// File: rtl/reflex_timer.sv
// Reaction-time controller: waits a pseudo-random delay after a start request,
// lights the stimulus LED, then counts whole milliseconds in BCD until the
// button is pressed. The ms generator phase is cleared on load and on stimulus
// so every measured interval begins on a clean millisecond boundary.
module reflex_timer #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10
) (
  input  logic          ck,
  input  logic          reset,
  reflex_timer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT, GO, MEASURE, DONE, FALSE
  } state_t;

  localparam logic [15:0] MIN_DLY = 16'(MIN_DELAY_MS);

  state_t      r_state;
  state_t      w_next;
  logic        r_start_q;
  logic        r_button_q;
  logic [15:0] r_lfsr;
  logic [15:0] r_dly;
  logic [15:0] r_ms_bcd;
  logic        r_timeout;

  logic        w_start_edge;
  logic        w_button_edge;
  logic [15:0] w_rand;
  logic        w_load;
  logic        w_dly_dec;
  logic        w_bcd_inc;
  logic        w_saturate;
  logic        w_tick_clear;
  logic        w_led;
  logic        w_valid;
  logic        w_false_start;

  // Four-digit BCD increment; each digit wraps 9->0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (res[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = 4'd0;
        end else begin
          res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // The previous levels reset high so a level already asserted at reset
  // does not count as an edge.
  assign w_start_edge  = bus.start  & ~r_start_q;
  assign w_button_edge = bus.button & ~r_button_q;
  assign w_rand        = {{(16-RAND_BITS){1'b0}}, r_lfsr[RAND_BITS-1:0]};

  // Edge-detect history and free-running Galois LFSR (x^16+x^14+x^13+x^11+1).
  always_ff @(posedge ck) begin
    if (reset) begin
      r_start_q  <= 1'b1;
      r_button_q <= 1'b1;
      r_lfsr     <= 16'hACE1;
    end else begin
      r_start_q  <= bus.start;
      r_button_q <= bus.button;
      r_lfsr     <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // FSM state register.
  always_ff @(posedge ck) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode, datapath strobes and Moore outputs.
  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_dly_dec     = 1'b0;
    w_bcd_inc     = 1'b0;
    w_saturate    = 1'b0;
    w_tick_clear  = 1'b0;
    w_led         = 1'b0;
    w_valid       = 1'b0;
    w_false_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_edge) w_next = LOAD;
      end
      LOAD: begin
        w_tick_clear = 1'b1;
        w_load       = 1'b1;
        w_next       = WAIT;
      end
      WAIT: begin
        // A press on the final tick still counts as a false start.
        if (w_button_edge) begin
          w_next = FALSE;
        end else if (bus.one_ms) begin
          if (r_dly == 16'd1) w_next    = GO;
          else                w_dly_dec = 1'b1;
        end
      end
      GO: begin
        w_tick_clear = 1'b1;
        w_next       = MEASURE;
      end
      MEASURE: begin
        w_led = 1'b1;
        // A press coinciding with a tick freezes the count before that tick.
        if (w_button_edge) begin
          w_next = DONE;
        end else if (bus.one_ms) begin
          if (r_ms_bcd == 16'h9999) begin
            w_next     = DONE;
            w_saturate = 1'b1;
          end else begin
            w_bcd_inc = 1'b1;
          end
        end
      end
      DONE: begin
        w_valid = 1'b1;
        if (w_start_edge) w_next = LOAD;
      end
      FALSE: begin
        w_false_start = 1'b1;
        if (w_start_edge) w_next = LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  // Delay counter, BCD result and timeout flag.
  always_ff @(posedge ck) begin
    if (reset) begin
      r_dly     <= 16'd0;
      r_ms_bcd  <= 16'h0000;
      r_timeout <= 1'b0;
    end else if (w_load) begin
      r_dly     <= MIN_DLY + w_rand;
      r_ms_bcd  <= 16'h0000;
      r_timeout <= 1'b0;
    end else begin
      if (w_dly_dec)  r_dly     <= r_dly - 16'd1;
      if (w_bcd_inc)  r_ms_bcd  <= bcd_inc(r_ms_bcd);
      if (w_saturate) r_timeout <= 1'b1;
    end
  end

  assign bus.tick_clear  = w_tick_clear;
  assign bus.led         = w_led;
  assign bus.ms_bcd      = r_ms_bcd;
  assign bus.valid       = w_valid;
  assign bus.timeout     = r_timeout;
  assign bus.false_start = w_false_start;

endmodule

// File: tb/tb_reflex_timer.sv
// Directed bench for reflex_timer with MIN_DELAY_MS=3, RAND_BITS=2. The bench
// emulates the ms generator: one_ms every 5 cycles, phase restarted by
// tick_clear or reset.
module tb_reflex_timer;
  logic ck = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tcnt    = 0;
  logic last_tick = 1'b0;
  logic last_clr  = 1'b0;

  reflex_timer_if ifc();

  reflex_timer #(.MIN_DELAY_MS(3), .RAND_BITS(2)) dut (
    .ck(ck),
    .reset(reset),
    .bus(ifc)
  );

  always #5 ck = ~ck;

  // One clock; afterwards last_tick says whether a tick the DUT could use
  // (not in LOAD/GO) was presented at that edge.
  task automatic step();
    logic clr, tk, rs;
    clr = ifc.tick_clear;
    tk  = ifc.one_ms;
    rs  = reset;
    @(posedge ck);
    #1;
    last_tick = tk & ~clr;
    last_clr  = clr;
    if (rs || clr)      tcnt = 0;
    else if (tcnt == 4) tcnt = 0;
    else                tcnt = tcnt + 1;
    ifc.one_ms = (tcnt == 4);
  endtask

  task automatic wait_ticks(input int n);
    int cnt, cyc;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < n * 5 + 20) begin
      step();
      cyc++;
      if (last_tick) cnt++;
    end
    if (cnt != n) begin
      n_tests++; n_fail++;
      $display("FAIL wait_ticks got=%0d exp=%0d", cnt, n);
    end
  endtask

  // Step until led rises; reports ticks consumed and whether tick_clear was
  // high in the cycle just before.
  task automatic wait_led(output int ticks, output logic clr_before);
    int cyc;
    ticks = 0;
    clr_before = 1'b0;
    cyc = 0;
    while (!ifc.led && cyc < 100) begin
      step();
      cyc++;
      if (last_tick) ticks++;
      clr_before = last_clr;
    end
    if (!ifc.led) begin
      n_tests++; n_fail++;
      $display("FAIL wait_led got=0 exp=1 after %0d cycles", cyc);
    end
  endtask

  task automatic start_edge();
    ifc.start = 1'b0;
    step();
    ifc.start = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic seen;
    reset = 1'b1; ifc.start = 1'b1; ifc.button = 1'b0; ifc.one_ms = 1'b0;
    repeat (3) step();
    n_tests++; if (ifc.tick_clear !== 1'b0) begin n_fail++; $display("FAIL rst_tick_clear got=%0b exp=0", ifc.tick_clear); end
    n_tests++; if (ifc.led !== 1'b0) begin n_fail++; $display("FAIL rst_led got=%0b exp=0", ifc.led); end
    n_tests++; if (ifc.ms_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_ms_bcd got=%h exp=0000", ifc.ms_bcd); end
    n_tests++; if (ifc.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", ifc.valid); end
    n_tests++; if (ifc.timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got=%0b exp=0", ifc.timeout); end
    n_tests++; if (ifc.false_start !== 1'b0) begin n_fail++; $display("FAIL rst_false_start got=%0b exp=0", ifc.false_start); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin step(); seen |= ifc.tick_clear; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_held_start got=%0b exp=0", seen); end
    start_edge();
    n_tests++; if (ifc.tick_clear !== 1'b1) begin n_fail++; $display("FAIL rst_load_clear got=%0b exp=1", ifc.tick_clear); end
    step();
    n_tests++; if (ifc.tick_clear !== 1'b0) begin n_fail++; $display("FAIL rst_wait_clear got=%0b exp=0", ifc.tick_clear); end
    n_tests++; if (ifc.led !== 1'b0) begin n_fail++; $display("FAIL rst_wait_led got=%0b exp=0", ifc.led); end
    reset = 1'b1; step(); reset = 1'b0; step();
  endtask

  task automatic test_normal();
    int ticks;
    logic clr;
    start_edge();
    n_tests++; if (ifc.tick_clear !== 1'b1) begin n_fail++; $display("FAIL norm_load_clear got=%0b exp=1", ifc.tick_clear); end
    wait_led(ticks, clr);
    n_tests++; if ((ticks >= 3 && ticks <= 6) !== 1'b1) begin n_fail++; $display("FAIL norm_delay_ticks got=%0d exp=3..6", ticks); end
    n_tests++; if (clr !== 1'b1) begin n_fail++; $display("FAIL norm_go_clear got=%0b exp=1", clr); end
    wait_ticks(37);
    ifc.button = 1'b1;
    step();
    n_tests++; if (ifc.ms_bcd !== 16'h0037) begin n_fail++; $display("FAIL norm_ms_bcd got=%h exp=0037", ifc.ms_bcd); end
    n_tests++; if (ifc.valid !== 1'b1) begin n_fail++; $display("FAIL norm_valid got=%0b exp=1", ifc.valid); end
    n_tests++; if (ifc.led !== 1'b0) begin n_fail++; $display("FAIL norm_led got=%0b exp=0", ifc.led); end
    n_tests++; if (ifc.timeout !== 1'b0) begin n_fail++; $display("FAIL norm_timeout got=%0b exp=0", ifc.timeout); end
    ifc.button = 1'b0;
    step();
  endtask

  task automatic test_false_start();
    logic seen;
    start_edge();
    step();
    n_tests++; if (ifc.valid !== 1'b0) begin n_fail++; $display("FAIL fs_valid_cleared got=%0b exp=0", ifc.valid); end
    n_tests++; if (ifc.ms_bcd !== 16'h0000) begin n_fail++; $display("FAIL fs_ms_cleared got=%h exp=0000", ifc.ms_bcd); end
    ifc.button = 1'b1;
    step();
    n_tests++; if (ifc.false_start !== 1'b1) begin n_fail++; $display("FAIL fs_flag got=%0b exp=1", ifc.false_start); end
    ifc.button = 1'b0;
    seen = 1'b0;
    repeat (60) begin step(); seen |= ifc.led; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL fs_led_seen got=%0b exp=0", seen); end
    n_tests++; if (ifc.ms_bcd !== 16'h0000) begin n_fail++; $display("FAIL fs_ms_bcd got=%h exp=0000", ifc.ms_bcd); end
    n_tests++; if (ifc.false_start !== 1'b1) begin n_fail++; $display("FAIL fs_flag_hold got=%0b exp=1", ifc.false_start); end
    start_edge();
    n_tests++; if (ifc.false_start !== 1'b0) begin n_fail++; $display("FAIL fs_flag_cleared got=%0b exp=0", ifc.false_start); end
  endtask

  task automatic test_coincident();
    int ticks, cyc;
    logic clr;
    wait_led(ticks, clr);
    wait_ticks(9);
    cyc = 0;
    while (!ifc.one_ms && cyc < 10) begin step(); cyc++; end
    ifc.button = 1'b1;
    step();
    n_tests++; if (ifc.ms_bcd !== 16'h0009) begin n_fail++; $display("FAIL coin_ms_bcd got=%h exp=0009", ifc.ms_bcd); end
    n_tests++; if (ifc.valid !== 1'b1) begin n_fail++; $display("FAIL coin_valid got=%0b exp=1", ifc.valid); end
    ifc.button = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    int ticks;
    logic clr;
    start_edge();
    wait_led(ticks, clr);
    wait_ticks(9999);
    n_tests++; if (ifc.ms_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_pre_ms got=%h exp=9999", ifc.ms_bcd); end
    n_tests++; if (ifc.led !== 1'b1) begin n_fail++; $display("FAIL sat_pre_led got=%0b exp=1", ifc.led); end
    n_tests++; if (ifc.timeout !== 1'b0) begin n_fail++; $display("FAIL sat_pre_timeout got=%0b exp=0", ifc.timeout); end
    wait_ticks(1);
    n_tests++; if (ifc.timeout !== 1'b1) begin n_fail++; $display("FAIL sat_timeout got=%0b exp=1", ifc.timeout); end
    n_tests++; if (ifc.valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid got=%0b exp=1", ifc.valid); end
    n_tests++; if (ifc.ms_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_ms got=%h exp=9999", ifc.ms_bcd); end
    n_tests++; if (ifc.led !== 1'b0) begin n_fail++; $display("FAIL sat_led got=%0b exp=0", ifc.led); end
    wait_ticks(2);
    n_tests++; if (ifc.ms_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_hold_ms got=%h exp=9999", ifc.ms_bcd); end
  endtask

  task automatic test_reset_mid();
    int ticks;
    logic clr, seen;
    start_edge();
    step();
    ifc.start = 1'b0; step(); ifc.start = 1'b1; step();
    n_tests++; if (ifc.tick_clear !== 1'b0) begin n_fail++; $display("FAIL mid_wait_start got=%0b exp=0", ifc.tick_clear); end
    wait_led(ticks, clr);
    wait_ticks(5);
    ifc.start = 1'b0; step(); ifc.start = 1'b1; step();
    n_tests++; if (ifc.led !== 1'b1) begin n_fail++; $display("FAIL mid_meas_start_led got=%0b exp=1", ifc.led); end
    n_tests++; if (ifc.tick_clear !== 1'b0) begin n_fail++; $display("FAIL mid_meas_start_clear got=%0b exp=0", ifc.tick_clear); end
    wait_ticks(2);
    n_tests++; if (ifc.ms_bcd !== 16'h0007) begin n_fail++; $display("FAIL mid_ms_bcd got=%h exp=0007", ifc.ms_bcd); end
    reset = 1'b1;
    step();
    n_tests++; if (ifc.led !== 1'b0) begin n_fail++; $display("FAIL mid_rst_led got=%0b exp=0", ifc.led); end
    n_tests++; if (ifc.ms_bcd !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_ms got=%h exp=0000", ifc.ms_bcd); end
    n_tests++; if (ifc.valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%0b exp=0", ifc.valid); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin step(); seen |= ifc.tick_clear | ifc.led; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle got=%0b exp=0", seen); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.start = 1'b0; ifc.button = 1'b0; ifc.one_ms = 1'b0; reset = 1'b1;
    test_reset();
    test_normal();
    test_false_start();
    test_coincident();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
